spi_master_fifo: RTL and testbench

Parametrised Wishbone SPI master: the successor to the fixed 8-bit simple SPI core. It has configurable word width, TX/RX FIFO depth and chip-select count. It also adds MSB/LSB-first shifting, a 16-bit clock divider, and overflow/collision status. It sits on the Wishbone peripheral bus and drives off-chip SPI slaves directly.

---
 rtl/spi_master_fifo.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: Wishbone SPI master with TX/RX FIFOs, programmable word width,
// MSB/LSB-first shifting, all four cpol/cpha modes, a 16-bit SCK divider and
// overflow/collision status.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   cyc_i, stb_i, we_i, adr_i  Wishbone request (adr_i selects one of 8 registers)
//   dat_i / dat_o              write data / read data (dat_o is valid in the ack cycle)
//   ack_o                      registered acknowledge, every access takes 2 cycles
//   inta_o                     level interrupt = spie & spif
//   sck_o, mosi_o, miso_i      SPI bus
//   ss_o[NSS-1:0]              active-low chip selects (inverse of the SS register)
//
// Register map: 0 CTRL, 1 STAT, 2 DATA, 3 DIV, 4 SS, 5..7 read as zero.
module spi_master_fifo #(
    parameter int DW  = 8,
    parameter int AW  = 2,
    parameter int NSS = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cyc_i,
    input  logic           stb_i,
    input  logic           we_i,
    input  logic [2:0]     adr_i,
    input  logic [31:0]    dat_i,
    output logic [31:0]    dat_o,
    output logic           ack_o,
    output logic           inta_o,
    output logic           sck_o,
    output logic           mosi_o,
    input  logic           miso_i,
    output logic [NSS-1:0] ss_o
);
    localparam int            DEPTH     = 1 << AW;
    localparam int            EW        = $clog2(2 * DW) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
    state_t state;

    // Bus-visible registers
    logic           spie, spe, lsbf, cpol, cpha;
    logic [15:0]    div_r;
    logic [NSS-1:0] ss_r;
    logic           spif, wcol, rxovf;

    // Bus decode: an access takes effect on the edge that ends its ack cycle
    logic acc, wr, rd;
    logic ctrl_wr, stat_wr, data_wr, div_wr, ss_wr, data_rd;
    assign acc     = ack_o & cyc_i & stb_i;
    assign wr      = acc & we_i;
    assign rd      = acc & ~we_i;
    assign ctrl_wr = wr & (adr_i == 3'd0);
    assign stat_wr = wr & (adr_i == 3'd1);
    assign data_wr = wr & (adr_i == 3'd2);
    assign div_wr  = wr & (adr_i == 3'd3);
    assign ss_wr   = wr & (adr_i == 3'd4);
    assign data_rd = rd & (adr_i == 3'd2);

    // Disabling the core discards both FIFOs. While spe stays 0 the TX FIFO
    // can still be preloaded, so the flush is tied to the 1->0 transition.
    logic flush;
    assign flush = ctrl_wr & spe & ~dat_i[6];

    // ---------------- FIFOs ----------------
    logic [DW-1:0] tx_mem [DEPTH];
    logic [DW-1:0] rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0]   tx_cnt, rx_cnt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push_req, rx_push, rx_pop, rx_ovf_set;
    logic [DW-1:0] rx_sr, tx_sr;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    assign tx_push     = data_wr & ~tx_full;
    assign tx_pop      = (state == S_LOAD) & spe;
    assign rx_pop      = data_rd & ~rx_empty;
    assign rx_push_req = (state == S_DONE) & spe & ~flush;
    // A bus pop in the same cycle frees a slot for the engine's push.
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovf_set  = rx_push_req & rx_full & ~rx_pop;

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp] <= dat_i[DW-1:0];
        if (rx_push) rx_mem[rx_wp] <= rx_sr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (AW + 1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (AW + 1)'(1);
                default: tx_cnt <= tx_cnt;
            endcase
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + (AW + 1)'(1);
                2'b01:   rx_cnt <= rx_cnt - (AW + 1)'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ---------------- Shift engine ----------------
    logic          lsbf_q, cpha_q;
    logic [15:0]   div_q, div_cnt;
    logic [EW-1:0] edge_cnt;
    logic [DW-1:0] tx_word;
    assign tx_word = tx_mem[tx_rp];

    function automatic logic out_bit(input logic [DW-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DW-1];
    endfunction

    function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            sck_o    <= 1'b0;
            mosi_o   <= 1'b0;
            lsbf_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else if (!spe) begin
            state <= S_IDLE;
            sck_o <= cpol;
        end else begin
            case (state)
                S_IDLE: begin
                    sck_o <= cpol;
                    if (!tx_empty || tx_push) state <= S_LOAD;
                end
                S_LOAD: begin
                    // Mode/divider are frozen here so mid-transfer CTRL/DIV
                    // writes only affect the next word.
                    lsbf_q   <= lsbf;
                    cpha_q   <= cpha;
                    div_q    <= div_r;
                    sck_o    <= cpol;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    rx_sr    <= '0;
                    if (cpha) begin
                        tx_sr <= tx_word;
                    end else begin
                        // cpha=0 presents the first bit before the leading edge
                        mosi_o <= out_bit(tx_word, lsbf);
                        tx_sr  <= shift_out(tx_word, lsbf);
                    end
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_cnt == div_q) begin
                        div_cnt  <= '0;
                        sck_o    <= ~sck_o;
                        edge_cnt <= edge_cnt + EW'(1);
                        // Even edges are leading. Sample on the leading edge for
                        // cpha=0, on the trailing edge for cpha=1; advance on the other.
                        if (~edge_cnt[0] ^ cpha_q) begin
                            rx_sr <= lsbf_q ? {miso_i, rx_sr[DW-1:1]}
                                            : {rx_sr[DW-2:0], miso_i};
                        end else begin
                            mosi_o <= out_bit(tx_sr, lsbf_q);
                            tx_sr  <= shift_out(tx_sr, lsbf_q);
                        end
                        if (edge_cnt == LAST_EDGE) state <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    state <= (!tx_empty || tx_push) ? S_LOAD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- Registers / status ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o <= 1'b0;
            spie  <= 1'b0;
            spe   <= 1'b0;
            lsbf  <= 1'b0;
            cpol  <= 1'b0;
            cpha  <= 1'b0;
            div_r <= '0;
            ss_r  <= '0;
            spif  <= 1'b0;
            wcol  <= 1'b0;
            rxovf <= 1'b0;
        end else begin
            ack_o <= cyc_i & stb_i & ~ack_o;
            if (ctrl_wr) begin
                spie <= dat_i[7];
                spe  <= dat_i[6];
                lsbf <= dat_i[5];
                cpol <= dat_i[3];
                cpha <= dat_i[2];
            end
            if (div_wr) div_r <= dat_i[15:0];
            if (ss_wr)  ss_r  <= dat_i[NSS-1:0];
            // Set beats write-1-to-clear in the same cycle
            if (rx_push_req)              spif  <= 1'b1;
            else if (stat_wr && dat_i[7]) spif  <= 1'b0;
            if (data_wr && tx_full)       wcol  <= 1'b1;
            else if (stat_wr && dat_i[6]) wcol  <= 1'b0;
            if (rx_ovf_set)               rxovf <= 1'b1;
            else if (stat_wr && dat_i[5]) rxovf <= 1'b0;
        end
    end

    logic busy;
    assign busy   = (state != S_IDLE);
    assign inta_o = spie & spif;
    assign ss_o   = ~ss_r;

    always_comb begin
        dat_o = '0;
        if (ack_o) begin
            case (adr_i)
                3'd0: dat_o[7:0] = {spie, spe, lsbf, 1'b0, cpol, cpha, 2'b00};
                3'd1: dat_o[7:0] = {spif, wcol, rxovf, busy, tx_full, tx_empty, rx_full, rx_empty};
                3'd2: if (!rx_empty) dat_o[DW-1:0] = rx_mem[rx_rp];
                3'd3: dat_o[15:0] = div_r;
                3'd4: dat_o[NSS-1:0] = ss_r;
                default: dat_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo. u0: DW=16, AW=2, NSS=2; u1: DW=8, AW=2,
// NSS=1. Both run with miso looped back to mosi. sel picks which DUT the bus
// tasks address.
module tb_spi_master_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, sel = 1'b0;
    logic [2:0]  adr = '0;
    logic [31:0] wdat = '0;
    logic        stb0, stb1, ack0, ack1, ack, inta0, inta1;
    logic        sck0, sck1, mosi0, mosi1;
    logic [31:0] dat0, dat1, rdat;
    logic [1:0]  ss0;
    logic [0:0]  ss1;

    assign stb0 = stb & ~sel;
    assign stb1 = stb & sel;
    assign ack  = sel ? ack1 : ack0;
    assign rdat = sel ? dat1 : dat0;

    spi_master_fifo #(.DW(16), .AW(2), .NSS(2)) u0 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb0), .we_i(we), .adr_i(adr),
        .dat_i(wdat), .dat_o(dat0), .ack_o(ack0), .inta_o(inta0), .sck_o(sck0),
        .mosi_o(mosi0), .miso_i(mosi0), .ss_o(ss0));

    spi_master_fifo #(.DW(8), .AW(2), .NSS(1)) u1 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb1), .we_i(we), .adr_i(adr),
        .dat_i(wdat), .dat_o(dat1), .ack_o(ack1), .inta_o(inta1), .sck_o(sck1),
        .mosi_o(mosi1), .miso_i(mosi1), .ss_o(ss1));

    int  vectors = 0, miscompares = 0;
    time last_edge_t = 0;

    // Slave model on u0: counts SCK edges and assembles the word it receives
    logic        cpol_tb = 1'b0, cpha_tb = 1'b0, lsbf_tb = 1'b0;
    int          mon0_cnt = 0;
    logic [15:0] slave_word = '0;
    always @(sck0) begin
        mon0_cnt++;
        if ((sck0 != cpol_tb) ^ cpha_tb)
            slave_word = lsbf_tb ? {mosi0, slave_word[15:1]} : {slave_word[14:0], mosi0};
    end

    // Edge timestamps on u1 for the divider check
    time t1 [64];
    int  idx1 = 0;
    always @(sck1) begin
        if (idx1 < 64) t1[idx1] = $time;
        idx1++;
    end

    task automatic wb_access(input logic w, input logic [2:0] a, input logic [31:0] d,
                             output logic [31:0] q);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack && n < 4);
        vectors++;
        if (!ack) begin
            miscompares++;
            $display("FAIL ack_timeout sel=%0d adr=%0d got ack=0 want 1", sel, a);
        end
        q = rdat;
        @(posedge clk); last_edge_t = $time; #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, a, d, dummy);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] q);
        wb_access(1'b0, a, 32'h0, q);
    endtask

    task automatic test_reset();
        logic [31:0] q;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // Start a u0 transfer with DIV=3 and hit reset mid-shift
        sel = 1'b0;
        wb_write(3'd3, 32'd3);
        wb_write(3'd0, 32'h40);
        wb_write(3'd2, 32'hFFFF);
        repeat (6) @(posedge clk);
        // First SCK edge lands 5 cycles after the write edge; MSB=1 on mosi
        vectors++;
        if (sck0 !== 1'b1 || mosi0 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_xfer sck/mosi got %b%b want 11", sck0, mosi0);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ack0, inta0, sck0, mosi0, ss0} !== 6'b000011 || dat0 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got ack/inta/sck/mosi/ss=%b%b%b%b%b dat=%h want 000011 dat=0",
                     ack0, inta0, sck0, mosi0, ss0, dat0);
        end
        vectors++;
        if (ss1 !== 1'b1 || ack1 !== 1'b0 || sck1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_u1 got ss=%b ack=%b sck=%b want 1 0 0", ss1, ack1, sck1);
        end
        @(negedge clk);
        vectors++;
        if (ack0 !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_ack got %b want 0", ack0);
        end
        wb_read(3'd1, q);
        vectors++;
        if (q !== 32'h05) begin
            miscompares++;
            $display("FAIL reset_stat got %h want 00000005", q);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] q;
        int base;
        sel = 1'b0;
        wb_write(3'd3, 32'd1);
        for (int m = 0; m < 8; m++) begin
            cpol_tb = m[2]; cpha_tb = m[1]; lsbf_tb = m[0];
            wb_write(3'd0, 32'h40 | (32'(m[0]) << 5) | (32'(m[2]) << 3) | (32'(m[1]) << 2));
            repeat (2) @(posedge clk);
            base = mon0_cnt;
            wb_write(3'd2, 32'hA5C3);
            repeat (100) @(posedge clk);
            wb_read(3'd1, q);
            vectors++;
            if (q !== 32'h84) begin
                miscompares++;
                $display("FAIL loop_stat mode=%0d got %h want 00000084", m, q);
            end
            wb_read(3'd2, q);
            vectors++;
            if (q !== 32'hA5C3) begin
                miscompares++;
                $display("FAIL loop_rx mode=%0d got %h want 0000a5c3", m, q);
            end
            vectors++;
            if (slave_word !== 16'hA5C3) begin
                miscompares++;
                $display("FAIL loop_slave mode=%0d got %h want a5c3", m, slave_word);
            end
            vectors++;
            if (mon0_cnt - base != 32) begin
                miscompares++;
                $display("FAIL loop_edges mode=%0d got %0d want 32", m, mon0_cnt - base);
            end
            vectors++;
            if (sck0 !== cpol_tb) begin
                miscompares++;
                $display("FAIL loop_idle_sck mode=%0d got %b want %b", m, sck0, cpol_tb);
            end
            wb_write(3'd1, 32'h80);
        end
    endtask

    task automatic test_divider();
        logic [31:0] q;
        time t_ack;
        int base, n, gap_err;
        sel = 1'b1;
        wb_write(3'd3, 32'd3);
        wb_write(3'd0, 32'hC0);
        base = idx1;
        wb_write(3'd2, 32'h5A);
        t_ack = last_edge_t;
        n = 0;
        while (!inta1 && n < 200) begin @(posedge clk); #1; n++; end
        // LOAD is the cycle after the write edge, 64 SHIFT cycles, DONE, then
        // spif appears on the 66th edge after the write edge.
        vectors++;
        if (!inta1 || n != 66) begin
            miscompares++;
            $display("FAIL div_spif_latency got %0d inta=%b want 66 inta=1", n, inta1);
        end
        vectors++;
        if (idx1 - base != 16) begin
            miscompares++;
            $display("FAIL div_edge_count got %0d want 16", idx1 - base);
        end
        vectors++;
        if (base < 64 && t1[base] - t_ack != 50) begin
            miscompares++;
            $display("FAIL div_first_edge got %0t want 50", t1[base] - t_ack);
        end
        gap_err = 0;
        for (int i = base + 1; i < base + 16 && i < 64; i++)
            if (t1[i] - t1[i-1] != 40) gap_err++;
        vectors++;
        if (gap_err != 0) begin
            miscompares++;
            $display("FAIL div_spacing got %0d bad gaps want 0", gap_err);
        end
        wb_read(3'd2, q);
        vectors++;
        if (q !== 32'h5A) begin
            miscompares++;
            $display("FAIL div_rx got %h want 0000005a", q);
        end
        wb_write(3'd1, 32'h80);
        sel = 1'b0;
    endtask

    task automatic test_tx_overflow();
        logic [31:0] q;
        int base;
        sel = 1'b0;
        cpol_tb = 1'b0; cpha_tb = 1'b0; lsbf_tb = 1'b0;
        wb_write(3'd1, 32'hE0);
        wb_write(3'd0, 32'h00);
        wb_write(3'd3, 32'd0);
        for (int i = 1; i <= 5; i++) wb_write(3'd2, 32'h1111 * i);
        wb_read(3'd1, q);
        vectors++;
        if (q !== 32'h49) begin
            miscompares++;
            $display("FAIL txovf_stat got %h want 00000049", q);
        end
        base = mon0_cnt;
        wb_write(3'd0, 32'h40);
        repeat (300) @(posedge clk);
        vectors++;
        if (mon0_cnt - base != 128) begin
            miscompares++;
            $display("FAIL txovf_edges got %0d want 128", mon0_cnt - base);
        end
        wb_read(3'd1, q);
        vectors++;
        if (q !== 32'hC6) begin
            miscompares++;
            $display("FAIL txovf_stat_after got %h want 000000c6", q);
        end
        for (int i = 1; i <= 4; i++) begin
            wb_read(3'd2, q);
            vectors++;
            if (q !== 32'h1111 * i) begin
                miscompares++;
                $display("FAIL txovf_rx%0d got %h want %h", i, q, 32'h1111 * i);
            end
        end
        wb_read(3'd2, q);
        vectors++;
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL txovf_empty_read got %h want 00000000", q);
        end
        wb_read(3'd1, q);
        vectors++;
        if (q !== 32'hC5) begin
            miscompares++;
            $display("FAIL txovf_stat_end got %h want 000000c5", q);
        end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] q;
        sel = 1'b0;
        wb_write(3'd1, 32'hE0);
        for (int i = 1; i <= 5; i++) wb_write(3'd2, 32'h0101 * i);
        repeat (300) @(posedge clk);
        wb_read(3'd1, q);
        vectors++;
        if (q !== 32'hA6) begin
            miscompares++;
            $display("FAIL rxovf_stat got %h want 000000a6", q);
        end
        for (int i = 1; i <= 4; i++) begin
            wb_read(3'd2, q);
            vectors++;
            if (q !== 32'h0101 * i) begin
                miscompares++;
                $display("FAIL rxovf_rx%0d got %h want %h", i, q, 32'h0101 * i);
            end
        end
        wb_read(3'd2, q);
        vectors++;
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL rxovf_5th_read got %h want 00000000", q);
        end
        wb_read(3'd1, q);
        vectors++;
        if (q !== 32'hA5) begin
            miscompares++;
            $display("FAIL rxovf_stat_end got %h want 000000a5", q);
        end
        wb_write(3'd1, 32'hE0);
    endtask

    task automatic test_irq_ss();
        logic [31:0] q;
        int n;
        sel = 1'b0;
        wb_write(3'd0, 32'hC0);
        wb_write(3'd2, 32'h3C3C);
        n = 0;
        while (!inta0 && n < 200) begin @(posedge clk); #1; n++; end
        // DIV=0: LOAD + 32 SHIFT + DONE, spif on the 34th edge
        vectors++;
        if (!inta0 || n != 34) begin
            miscompares++;
            $display("FAIL irq_rise got %0d inta=%b want 34 inta=1", n, inta0);
        end
        wb_write(3'd1, 32'h80);
        @(negedge clk);
        vectors++;
        if (inta0 !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear got %b want 0", inta0);
        end
        wb_read(3'd2, q);
        vectors++;
        if (q !== 32'h3C3C) begin
            miscompares++;
            $display("FAIL irq_rx got %h want 00003c3c", q);
        end
        wb_write(3'd4, 32'h2);
        @(negedge clk);
        vectors++;
        if (ss0 !== 2'b01) begin
            miscompares++;
            $display("FAIL ss_out got %b want 01", ss0);
        end
        wb_read(3'd4, q);
        vectors++;
        if (q !== 32'h2) begin
            miscompares++;
            $display("FAIL ss_readback got %h want 00000002", q);
        end
        wb_read(3'd0, q);
        vectors++;
        if (q !== 32'hC0) begin
            miscompares++;
            $display("FAIL ctrl_readback got %h want 000000c0", q);
        end
        wb_write(3'd5, 32'hFF);
        wb_read(3'd5, q);
        vectors++;
        if (q !== 32'h0) begin
            miscompares++;
            $display("FAIL reg5_read got %h want 00000000", q);
        end
    endtask

    task automatic test_abort();
        logic [31:0] q;
        sel = 1'b0;
        wb_write(3'd0, 32'h40);
        wb_write(3'd3, 32'd3);
        wb_write(3'd2, 32'hF0F0);
        repeat (20) @(posedge clk);
        wb_write(3'd0, 32'h00);
        repeat (200) @(posedge clk);
        wb_read(3'd1, q);
        vectors++;
        if (q !== 32'h05) begin
            miscompares++;
            $display("FAIL abort_stat got %h want 00000005", q);
        end
        vectors++;
        if (sck0 !== 1'b0 || inta0 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle got sck=%b inta=%b want 0 0", sck0, inta0);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_divider();
        test_tx_overflow();
        test_rx_overflow();
        test_irq_ss();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
